// File: rtl/ras_pc_sequencer_if.sv
// Handshake/bus bundle between the PC sequencer and its environment
// (decoder, target LUT, return-address stack).
interface ras_pc_sequencer_if #(
    parameter int D           = 12,
    parameter int STACK_DEPTH = 8
);
    localparam int DW = $clog2(STACK_DEPTH) + 1;

    logic          start;
    logic [D-1:0]  start_pc;
    logic          is_call;
    logic          is_ret;
    logic          is_branch;
    logic          branch_taken;
    logic [D-1:0]  target_in;
    logic [D-1:0]  ras_target;
    logic          halt_req;

    logic [D-1:0]  pc;
    logic [1:0]    stage;
    logic          ras_call;
    logic          ras_ret;
    logic [DW-1:0] depth;
    logic          busy;
    logic          done;
    logic          fault;
    logic [1:0]    fault_code;

    // Environment side: drives decode/control, observes sequencer state
    modport master (
        output start, start_pc, is_call, is_ret, is_branch, branch_taken,
               target_in, ras_target, halt_req,
        input  pc, stage, ras_call, ras_ret, depth, busy, done, fault, fault_code
    );

    // Sequencer side
    modport slave (
        input  start, start_pc, is_call, is_ret, is_branch, branch_taken,
               target_in, ras_target, halt_req,
        output pc, stage, ras_call, ras_ret, depth, busy, done, fault, fault_code
    );
endinterface

// File: rtl/ras_pc_sequencer.sv
// Program-counter sequencer and return-address-stack controller.
// Steps each instruction through a 4-phase stage counter, owns the PC,
// issues push/pop strobes in stage 01 and tracks stack occupancy so that
// an illegal call/return lands in FAULT instead of corrupting the stack.
module ras_pc_sequencer #(
    parameter int D           = 12,
    parameter int STACK_DEPTH = 8
) (
    input logic               clk,
    input logic               reset,
    ras_pc_sequencer_if.slave bus
);
    localparam int DW = $clog2(STACK_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

    state_t        state_q, state_n;
    logic [D-1:0]  pc_q, pc_n;
    logic [1:0]    stage_q, stage_n;
    logic [DW-1:0] depth_q, depth_n;
    logic [1:0]    fcode_q, fcode_n;
    logic          call_s, ret_s;

    // State, PC, stage, occupancy and fault-code registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            stage_q <= '0;
            depth_q <= '0;
            fcode_q <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            stage_q <= stage_n;
            depth_q <= depth_n;
            fcode_q <= fcode_n;
        end
    end

    // Next-state, stage-01 strobe decisions and stage-11 PC update
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        stage_n = stage_q;
        depth_n = depth_q;
        fcode_n = fcode_q;
        call_s  = 1'b0;
        ret_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_n = S_RUN;
                    pc_n    = bus.start_pc;
                    stage_n = '0;
                    depth_n = '0;
                end
            end

            S_RUN: begin
                stage_n = stage_q + 2'd1;

                if (stage_q == 2'b01) begin
                    // Illegal requests freeze pc/stage/depth where they are
                    if (bus.is_call && bus.is_ret) begin
                        state_n = S_FAULT;
                        stage_n = stage_q;
                        fcode_n = 2'b11;
                    end else if (bus.is_call) begin
                        if (depth_q == DW'(STACK_DEPTH)) begin
                            state_n = S_FAULT;
                            stage_n = stage_q;
                            fcode_n = 2'b01;
                        end else begin
                            call_s  = 1'b1;
                            depth_n = depth_q + DW'(1);
                        end
                    end else if (bus.is_ret) begin
                        if (depth_q == '0) begin
                            state_n = S_FAULT;
                            stage_n = stage_q;
                            fcode_n = 2'b10;
                        end else begin
                            ret_s   = 1'b1;
                            depth_n = depth_q - DW'(1);
                        end
                    end
                end

                if (stage_q == 2'b11) begin
                    if (bus.halt_req) begin
                        state_n = S_HALT;
                    end else if (bus.is_ret) begin
                        pc_n = bus.ras_target;
                    end else if (bus.is_call) begin
                        pc_n = bus.target_in;
                    end else if (bus.is_branch && bus.branch_taken) begin
                        pc_n = bus.target_in;
                    end else begin
                        pc_n = pc_q + D'(1);
                    end
                end
            end

            default: ;
        endcase

        // The stack must not see a strobe in a cycle whose edge is a reset
        if (reset) begin
            call_s = 1'b0;
            ret_s  = 1'b0;
        end
    end

    // Registered state and strobes driven out through the interface
    always_comb begin
        bus.pc         = pc_q;
        bus.stage      = stage_q;
        bus.depth      = depth_q;
        bus.fault_code = fcode_q;
        bus.busy       = (state_q == S_RUN);
        bus.done       = (state_q == S_HALT);
        bus.fault      = (state_q == S_FAULT);
        bus.ras_call   = call_s;
        bus.ras_ret    = ret_s;
    end
endmodule

// File: tb/tb_ras_pc_sequencer.sv
// Scoreboard bench for ras_pc_sequencer: stimulus pushes expected snapshots
// and expected strobes into queues; a negedge monitor pops and compares.
module tb_ras_pc_sequencer;
    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    ras_pc_sequencer_if #(.D(12), .STACK_DEPTH(8)) bus ();

    ras_pc_sequencer #(.D(12), .STACK_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [11:0] pc;
        int         stage;   // -1 = don't care
        logic [3:0] depth;
        logic       busy;
        logic       done;
        logic       fault;
        logic [1:0] fcode;
    } snap_t;

    typedef struct {
        string       name;
        int          kind;   // 1 = call, 2 = ret
        logic [11:0] pc;
    } strobe_t;

    snap_t   snap_q[$];
    strobe_t strobe_q[$];

    logic [11:0] cur_pc;
    logic [3:0]  cur_depth;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: strobe checks whenever a strobe is presented, snapshots when due
    always @(negedge clk) begin
        if (bus.ras_call || bus.ras_ret) begin
            n_cmp++;
            if (strobe_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: got call=%0b ret=%0b pc=%h, required none",
                         bus.ras_call, bus.ras_ret, bus.pc);
            end else begin
                strobe_t e;
                int k;
                e = strobe_q.pop_front();
                k = bus.ras_call ? (bus.ras_ret ? 3 : 1) : 2;
                if (k != e.kind || bus.pc != e.pc) begin
                    n_bad++;
                    $display("FAIL %s: got kind=%0d pc=%h, required kind=%0d pc=%h",
                             e.name, k, bus.pc, e.kind, e.pc);
                end
            end
        end
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            snap_t s;
            s = snap_q.pop_front();
            n_cmp++;
            if (bus.pc !== s.pc || (s.stage >= 0 && bus.stage !== 2'(s.stage)) ||
                bus.depth !== s.depth || bus.busy !== s.busy || bus.done !== s.done ||
                bus.fault !== s.fault || bus.fault_code !== s.fcode) begin
                n_bad++;
                $display("FAIL %s: got pc=%h st=%0d dp=%0d b=%0b d=%0b f=%0b fc=%0d, required pc=%h st=%0d dp=%0d b=%0b d=%0b f=%0b fc=%0d",
                         s.name, bus.pc, bus.stage, bus.depth, bus.busy, bus.done,
                         bus.fault, bus.fault_code, s.pc, s.stage, s.depth, s.busy,
                         s.done, s.fault, s.fcode);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input string nm, input logic [11:0] p, input int st,
                        input logic [3:0] dp, input logic bz, input logic dn,
                        input logic ft, input logic [1:0] fc);
        snap_t s;
        s.cyc = cyc; s.name = nm; s.pc = p; s.stage = st; s.depth = dp;
        s.busy = bz; s.done = dn; s.fault = ft; s.fcode = fc;
        snap_q.push_back(s);
    endtask

    task automatic clear_ctl();
        bus.start = 1'b0; bus.start_pc = '0; bus.is_call = 1'b0; bus.is_ret = 1'b0;
        bus.is_branch = 1'b0; bus.branch_taken = 1'b0; bus.target_in = '0;
        bus.ras_target = '0; bus.halt_req = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        clear_ctl();
        tick();
        tick();
        reset = 1'b0;
        cur_pc = '0;
        cur_depth = '0;
        snap(nm, 12'h000, 0, 4'd0, 0, 0, 0, 2'b00);
    endtask

    task automatic do_start(input logic [11:0] p);
        bus.start = 1'b1;
        bus.start_pc = p;
        tick();
        bus.start = 1'b0;
        bus.start_pc = 12'hABC;
        cur_pc = p;
        cur_depth = '0;
    endtask

    // One full legal instruction, entered and left in stage 00
    task automatic instr(input string nm, input logic c, input logic r, input logic b,
                         input logic t, input logic [11:0] tgt, input logic [11:0] rtgt,
                         input logic h, input int strobe, input logic [11:0] exp_pc,
                         input logic [3:0] exp_depth, input logic exp_done);
        bus.is_call = c; bus.is_ret = r; bus.is_branch = b; bus.branch_taken = t;
        bus.target_in = tgt; bus.ras_target = rtgt; bus.halt_req = h;
        snap({nm, "_s0"}, cur_pc, 0, cur_depth, 1, 0, 0, 2'b00);
        tick();
        if (strobe != 0) begin
            strobe_t e;
            e.name = {nm, "_strobe"}; e.kind = strobe; e.pc = cur_pc;
            strobe_q.push_back(e);
        end
        snap({nm, "_s1"}, cur_pc, 1, cur_depth, 1, 0, 0, 2'b00);
        tick();
        snap({nm, "_s2"}, cur_pc, 2, exp_depth, 1, 0, 0, 2'b00);
        tick();
        snap({nm, "_s3"}, cur_pc, 3, exp_depth, 1, 0, 0, 2'b00);
        tick();
        clear_ctl();
        if (exp_done) snap({nm, "_end"}, exp_pc, -1, exp_depth, 0, 1, 0, 2'b00);
        else          snap({nm, "_end"}, exp_pc, 0, exp_depth, 1, 0, 0, 2'b00);
        cur_pc = exp_pc;
        cur_depth = exp_depth;
    endtask

    // Instruction that must fault in stage 01 with no strobe
    task automatic fault_instr(input string nm, input logic c, input logic r,
                               input logic [11:0] tgt, input logic [11:0] rtgt,
                               input logic [1:0] code);
        bus.is_call = c; bus.is_ret = r; bus.target_in = tgt; bus.ras_target = rtgt;
        snap({nm, "_s0"}, cur_pc, 0, cur_depth, 1, 0, 0, 2'b00);
        tick();
        snap({nm, "_s1"}, cur_pc, 1, cur_depth, 1, 0, 0, 2'b00);
        tick();
        snap({nm, "_fault"}, cur_pc, 1, cur_depth, 0, 0, 1, code);
        tick();
        tick();
        tick();
        snap({nm, "_frozen"}, cur_pc, 1, cur_depth, 0, 0, 1, code);
        clear_ctl();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0;
        reset = 1'b1;
        clear_ctl();

        // Sequential execution from 0x010
        do_reset("reset_vals");
        do_start(12'h010);
        instr("seq0", 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h011, 4'd0, 0);
        instr("seq1", 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h012, 4'd0, 0);
        instr("seq2", 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h013, 4'd0, 0);

        // Call / return pair, then branches
        do_reset("reset_cr");
        do_start(12'h020);
        instr("call", 1, 0, 0, 0, 12'h100, 12'h000, 0, 1, 12'h100, 4'd1, 0);
        instr("body", 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h101, 4'd1, 0);
        instr("ret",  0, 1, 0, 0, 12'h555, 12'h021, 0, 2, 12'h021, 4'd0, 0);
        instr("br_taken", 0, 0, 1, 1, 12'h2A0, 12'h000, 0, 0, 12'h2A0, 4'd0, 0);
        instr("br_not",   0, 0, 1, 0, 12'h333, 12'h000, 0, 0, 12'h2A1, 4'd0, 0);

        // PC wrap at 0xFFF
        do_reset("reset_wrap");
        do_start(12'hFFE);
        instr("pre_wrap", 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'hFFF, 4'd0, 0);
        instr("wrap",     0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 4'd0, 0);

        // Nested calls up to full, then overflow
        do_reset("reset_nest");
        do_start(12'h000);
        for (int i = 0; i < 8; i++) begin
            logic [11:0] tg;
            tg = 12'h100 + 12'(i * 16);
            instr($sformatf("nest%0d", i), 1, 0, 0, 0, tg, 12'h000, 0, 1, tg, 4'(i + 1), 0);
        end
        fault_instr("overflow", 1, 0, 12'h400, 12'h000, 2'b01);

        // Return on empty stack
        do_reset("reset_uf");
        do_start(12'h040);
        fault_instr("underflow", 0, 1, 12'h000, 12'h7AB, 2'b10);

        // Call and return together
        do_reset("reset_both");
        do_start(12'h050);
        fault_instr("call_ret", 1, 1, 12'h123, 12'h456, 2'b11);

        // Halt has priority over a taken branch; start ignored afterwards
        do_reset("reset_halt");
        do_start(12'h060);
        instr("pre_halt", 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h061, 4'd0, 0);
        instr("halt", 0, 0, 1, 1, 12'h003, 12'h000, 1, 0, 12'h061, 4'd0, 1);
        bus.start = 1'b1; bus.start_pc = 12'h999;
        tick();
        bus.start = 1'b0;
        tick();
        snap("halt_held", 12'h061, -1, 4'd0, 0, 1, 0, 2'b00);

        // Reset landing in stage 01 of a call: no strobe, back to reset values
        do_reset("reset_mid_pre");
        do_start(12'h070);
        bus.is_call = 1'b1; bus.target_in = 12'h200;
        snap("mid_s0", 12'h070, 0, 4'd0, 1, 0, 0, 2'b00);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        snap("mid_reset", 12'h000, 0, 4'd0, 0, 0, 0, 2'b00);
        tick();
        snap("mid_idle", 12'h000, 0, 4'd0, 0, 0, 0, 2'b00);
        clear_ctl();
        tick();
        tick();

        // Every expectation must have been consumed
        n_cmp++;
        if (strobe_q.size() != 0) begin
            n_bad++;
            $display("FAIL strobe_drain: got %0d missing strobes, required 0", strobe_q.size());
        end
        n_cmp++;
        if (snap_q.size() != 0) begin
            n_bad++;
            $display("FAIL snap_drain: got %0d unchecked snapshots, required 0", snap_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
